axi_burst_addr_gen: RTL and testbench

Per-beat address sequencer for one AXI read or write address channel. It accepts a burst command (start address, burst type, size, length) over a valid/ready handshake. It then issues one beat address per accepted beat, with a last flag, using an internal `axi_addr` instance to compute each following address. It sits between the AXI AW/AR slave port and the data-path beat logic (memory or register read/write) of the adapters.

---
 rtl/axi_burst_addr_gen.sv | 130 +++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_addr_gen.sv
// AXI burst beat-address sequencer: latches one AW/AR command and walks its beats,
// plus the axi_addr next-address helper it uses.

module axi_addr #(
    parameter int         ADDR_WIDTH = 12,
    parameter logic       ALIGN_ADDR = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [1:0]            burst,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        incr      = ONE << size;
        sum       = last_addr + incr;
        // Boundary is (len+1) << size; non power-of-two lengths give whatever the mask yields
        wrap_mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
        next_addr = sum;
        if (burst == 2'b10)
            next_addr = (last_addr & ~wrap_mask) | (sum & wrap_mask);
        if (burst == 2'b00)
            next_addr = last_addr;
        else if (ALIGN_ADDR)
            next_addr = next_addr & ~(incr - ONE);
    end
endmodule

module axi_burst_addr_gen #(
    parameter logic ALIGN_ADDR = 1'b1,
    parameter int   ADDR_WIDTH = 12,
    parameter int   DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [1:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [7:0]            cmd_len,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [7:0]            beat_idx,
    output logic                  beat_last
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [1:0] burst;
        logic [2:0] size;
        logic [7:0] len;
    } burst_cfg_t;

    state_t                state_q, state_d;
    burst_cfg_t            cfg_q, cfg_in;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cmd_hs, beat_hs;

    always_comb begin
        cfg_in.burst = (cmd_burst == 2'b11) ? 2'b01 : cmd_burst;
        cfg_in.size  = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
        cfg_in.len   = cmd_len;
    end

    axi_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ALIGN_ADDR (ALIGN_ADDR)
    ) u_axi_addr (
        .last_addr (beat_addr),
        .burst     (cfg_q.burst),
        .size      (cfg_q.size),
        .len       (cfg_q.len),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Handshake readiness depends on state only, never on the partner's valid/ready
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = BURST;
            end
            BURST: begin
                beat_valid = 1'b1;
                if (beat_ready && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign beat_hs = beat_valid && beat_ready;

    // Outputs freeze on the final beat so the consumer still sees them after the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            beat_addr <= '0;
            beat_idx  <= '0;
            beat_last <= 1'b0;
        end else if (cmd_hs) begin
            cfg_q     <= cfg_in;
            beat_addr <= cmd_addr;
            beat_idx  <= '0;
            beat_last <= (cmd_len == 8'd0);
        end else if (beat_hs && !beat_last) begin
            beat_addr <= next_addr;
            beat_idx  <= beat_idx + 8'd1;
            beat_last <= (beat_idx + 8'd1 == cfg_q.len);
        end
    end
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Randomized and directed bench for axi_burst_addr_gen, checked against an
// arithmetic burst-address model.

module tb_axi_burst_addr_gen;
    localparam int AW = 12;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_burst;
    logic [2:0]    cmd_size;
    logic [7:0]    cmd_len;
    logic          beat_valid, beat_ready;
    logic [AW-1:0] beat_addr;
    logic [7:0]    beat_idx;
    logic          beat_last;

    int checks = 0;
    int passed = 0;

    logic [AW-1:0] q_addr[$];
    int            q_idx[$];
    logic          q_last[$];
    bit            lat_ok, post_idle, timed_out;
    int            hold_err;

    axi_burst_addr_gen #(.ALIGN_ADDR(1'b1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
        .beat_idx(beat_idx), .beat_last(beat_last)
    );

    always #5 clk = ~clk;

    // Address of beat i from AXI rules: start as given, then size-aligned steps
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input logic [1:0] b,
                                                 input logic [2:0] s, input logic [7:0] l, input int i);
        longint nb, start, al, bound, lower, r;
        int sz;
        sz    = (s > 3) ? 3 : int'(s);
        nb    = longint'(1) << sz;
        start = longint'(a);
        al    = (start / nb) * nb;
        if (i == 0) return a;
        if (b == 2'b00) r = start;
        else if (b == 2'b10) begin
            bound = nb * (longint'(l) + 1);
            lower = (start / bound) * bound;
            r     = lower + ((al - lower) + longint'(i) * nb) % bound;
        end else r = al + longint'(i) * nb;
        return AW'(r);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic collect(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] s,
                           input logic [7:0] l, input bit rnd);
        int            cyc;
        bit            stalled;
        logic [AW-1:0] ha;
        logic [7:0]    hi;
        logic          hl;
        q_addr.delete(); q_idx.delete(); q_last.delete();
        timed_out = 0; hold_err = 0; lat_ok = 0; post_idle = 0;
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 100) begin step(); cyc++; end
        if (cmd_ready !== 1'b1) begin timed_out = 1; return; end
        cmd_valid = 1; cmd_addr = a; cmd_burst = b; cmd_size = s; cmd_len = l;
        step();
        cmd_valid = 0; cmd_addr = AW'($urandom); cmd_len = 8'($urandom);
        lat_ok  = (beat_valid === 1'b1) && (beat_idx === 8'd0);
        stalled = 0; cyc = 0; ha = '0; hi = '0; hl = 0;
        while (q_addr.size() < int'(l) + 1 && cyc < 2000) begin
            if (stalled && {beat_addr, beat_idx, beat_last} !== {ha, hi, hl}) hold_err++;
            beat_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (beat_valid === 1'b1 && beat_ready) begin
                q_addr.push_back(beat_addr); q_idx.push_back(int'(beat_idx)); q_last.push_back(beat_last);
                stalled = 0;
            end else if (beat_valid === 1'b1) begin
                stalled = 1; ha = beat_addr; hi = beat_idx; hl = beat_last;
            end
            step(); cyc++;
        end
        beat_ready = 0;
        if (q_addr.size() < int'(l) + 1) timed_out = 1;
        post_idle = (cmd_ready === 1'b1) && (beat_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; beat_ready = 0;
        cmd_addr = '0; cmd_burst = 0; cmd_size = 0; cmd_len = 0;
        #3;
        checks++;
        if ({cmd_ready, beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, 1'b0, {AW{1'b0}}, 8'd0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b addr=%h idx=%0d last=%b, want 1 0 000 0 0",
                     cmd_ready, beat_valid, beat_addr, beat_idx, beat_last);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        step();
        checks++;
        if ({cmd_ready, beat_valid, beat_last} !== 3'b100)
            $display("FAIL reset_release: got rdy=%b vld=%b last=%b, want 1 0 0", cmd_ready, beat_valid, beat_last);
        else passed++;
    endtask

    task automatic test_directed(input string name, input logic [AW-1:0] a, input logic [1:0] b,
                                 input logic [2:0] s, input logic [7:0] l, input logic [AW-1:0] exp[]);
        collect(a, b, s, l, 0);
        checks++;
        if (timed_out || !lat_ok)
            $display("FAIL %s_start: timed_out=%0d lat_ok=%0d, want 0 1", name, timed_out, lat_ok);
        else passed++;
        for (int i = 0; i < exp.size() && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== exp[i] || q_idx[i] != i || q_last[i] !== (i == exp.size() - 1))
                $display("FAIL %s_beat%0d: got addr=%h idx=%0d last=%b, want addr=%h idx=%0d last=%b",
                         name, i, q_addr[i], q_idx[i], q_last[i], exp[i], i, (i == exp.size() - 1));
            else passed++;
        end
        checks++;
        if (!post_idle || beat_addr !== exp[exp.size()-1] || int'(beat_idx) != exp.size() - 1 || beat_last !== 1'b1)
            $display("FAIL %s_end: got idle=%0d addr=%h idx=%0d last=%b, want 1 %h %0d 1",
                     name, post_idle, beat_addr, beat_idx, beat_last, exp[exp.size()-1], exp.size() - 1);
        else passed++;
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 100) begin step(); cyc++; end
        cmd_valid = 1; cmd_addr = 12'h000; cmd_burst = 2'd1; cmd_size = 3'd3; cmd_len = 8'd2;
        step();
        cmd_valid = 0; beat_ready = 1;
        step();
        beat_ready = 0; cmd_valid = 1; cmd_addr = 12'h100; cmd_size = 3'd2; cmd_len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({beat_valid, cmd_ready, beat_addr, beat_idx, beat_last} !== {1'b1, 1'b0, 12'h008, 8'd1, 1'b0})
                $display("FAIL bp_stall%0d: got vld=%b rdy=%b addr=%h idx=%0d last=%b, want 1 0 008 1 0",
                         i, beat_valid, cmd_ready, beat_addr, beat_idx, beat_last);
            else passed++;
            if (i < 3) step();
        end
        beat_ready = 1;
        step();
        checks++;
        if ({beat_valid, cmd_ready, beat_addr, beat_idx, beat_last} !== {1'b1, 1'b0, 12'h010, 8'd2, 1'b1})
            $display("FAIL bp_resume: got vld=%b rdy=%b addr=%h idx=%0d last=%b, want 1 0 010 2 1",
                     beat_valid, cmd_ready, beat_addr, beat_idx, beat_last);
        else passed++;
        step();
        checks++;
        if ({beat_valid, cmd_ready, beat_addr} !== {1'b0, 1'b1, 12'h010})
            $display("FAIL bp_idle: got vld=%b rdy=%b addr=%h, want 0 1 010", beat_valid, cmd_ready, beat_addr);
        else passed++;
        step();
        cmd_valid = 0;
        checks++;
        if ({beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, 12'h100, 8'd0, 1'b1})
            $display("FAIL bp_next_cmd: got vld=%b addr=%h idx=%0d last=%b, want 1 100 0 1",
                     beat_valid, beat_addr, beat_idx, beat_last);
        else passed++;
        step();
        beat_ready = 0;
    endtask

    task automatic test_back_to_back();
        int hs_cyc[$];
        int cyc = 0;
        cmd_valid = 1; cmd_addr = 12'h020; cmd_burst = 2'd1; cmd_size = 3'd2; cmd_len = 8'd2;
        beat_ready = 1;
        while (hs_cyc.size() < 4 && cyc < 60) begin
            if (cmd_ready === 1'b1) hs_cyc.push_back(cyc);
            step(); cyc++;
        end
        cmd_valid = 0;
        checks++;
        if (hs_cyc.size() != 4) $display("FAIL b2b_count: got %0d handshakes, want 4", hs_cyc.size());
        else passed++;
        for (int i = 1; i < hs_cyc.size(); i++) begin
            checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 4)
                $display("FAIL b2b_period%0d: got %0d cycles, want 4", i, hs_cyc[i] - hs_cyc[i-1]);
            else passed++;
        end
        cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 20) begin step(); cyc++; end
        beat_ready = 0;
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] exp2[] = '{12'h080, 12'h084};
        int cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 100) begin step(); cyc++; end
        cmd_valid = 1; cmd_addr = 12'h040; cmd_burst = 2'd1; cmd_size = 3'd2; cmd_len = 8'd7;
        step();
        cmd_valid = 0; beat_ready = 1; cyc = 0;
        while (beat_idx !== 8'd2 && cyc < 20) begin step(); cyc++; end
        checks++;
        if (beat_idx !== 8'd2 || beat_addr !== 12'h048)
            $display("FAIL rst_mid_reach: got idx=%0d addr=%h, want 2 048", beat_idx, beat_addr);
        else passed++;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({cmd_ready, beat_valid, beat_addr, beat_idx, beat_last} !== {1'b1, 1'b0, {AW{1'b0}}, 8'd0, 1'b0})
            $display("FAIL rst_mid_async: got rdy=%b vld=%b addr=%h idx=%0d last=%b, want 1 0 000 0 0",
                     cmd_ready, beat_valid, beat_addr, beat_idx, beat_last);
        else passed++;
        @(negedge clk); rst_n = 1;
        step(); step();
        checks++;
        if ({cmd_ready, beat_valid} !== 2'b10)
            $display("FAIL rst_mid_after: got rdy=%b vld=%b, want 1 0", cmd_ready, beat_valid);
        else passed++;
        beat_ready = 0;
        test_directed("rst_restart", 12'h080, 2'd1, 3'd2, 8'd1, exp2);
    endtask

    task automatic test_random(input int n);
        logic [AW-1:0] a;
        logic [1:0]    b;
        logic [2:0]    s;
        logic [7:0]    l;
        logic [AW-1:0] e;
        int            lens[4] = '{1, 3, 7, 15};
        for (int t = 0; t < n; t++) begin
            a = AW'($urandom); b = 2'($urandom); s = 3'($urandom);
            l = (b == 2'b10) ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 20));
            collect(a, b, s, l, 1);
            checks++;
            if (timed_out || !lat_ok || hold_err != 0 || !post_idle)
                $display("FAIL rnd%0d_flow: timeout=%0d lat=%0d hold_err=%0d idle=%0d, want 0 1 0 1",
                         t, timed_out, lat_ok, hold_err, post_idle);
            else passed++;
            for (int i = 0; i < q_addr.size(); i++) begin
                e = model_addr(a, b, s, l, i);
                checks++;
                if (q_addr[i] !== e || q_idx[i] != i || q_last[i] !== (i == int'(l)))
                    $display("FAIL rnd%0d_beat%0d (a=%h b=%0d s=%0d l=%0d): got addr=%h idx=%0d last=%b, want %h %0d %b",
                             t, i, a, b, s, l, q_addr[i], q_idx[i], q_last[i], e, i, (i == int'(l)));
                else passed++;
            end
        end
    endtask

    initial begin
        logic [AW-1:0] e_incr[]  = '{12'h000, 12'h004, 12'h008, 12'h00C};
        logic [AW-1:0] e_unal[]  = '{12'h007, 12'h008, 12'h00C, 12'h010, 12'h014};
        logic [AW-1:0] e_wrap[]  = '{12'h004, 12'h008, 12'h00C, 12'h000};
        logic [AW-1:0] e_fixed[] = '{12'h000, 12'h000, 12'h000};
        logic [AW-1:0] e_clamp[] = '{12'h003, 12'h008, 12'h010};
        logic [AW-1:0] e_rsvd[]  = '{12'hFFC, 12'h000, 12'h004};
        test_reset();
        test_directed("incr", 12'h000, 2'd1, 3'd2, 8'd3, e_incr);
        test_directed("unaligned", 12'h007, 2'd1, 3'd2, 8'd4, e_unal);
        test_directed("wrap", 12'h004, 2'd2, 3'd2, 8'd3, e_wrap);
        test_directed("fixed", 12'h000, 2'd0, 3'd2, 8'd2, e_fixed);
        test_directed("size_clamp", 12'h003, 2'd1, 3'd6, 8'd2, e_clamp);
        test_directed("rsvd_incr_wrap", 12'hFFC, 2'd3, 3'd2, 8'd2, e_rsvd);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_random(40);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
